// File: rtl/arith_pred_pkg.sv
// arith_pred_pkg: FSM state encoding and step-count helper shared by the serial comparator.
package arith_pred_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic int step_count(input int word_width, input int step_word_width);
        return (word_width + step_word_width - 1) / step_word_width;
    endfunction
endpackage

// File: rtl/arith_pred_step.sv
// arith_pred_step: one slice of A+~B+carry; carries are tapped at the highest bit set in real_mask.
module arith_pred_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] real_mask,
    output logic [WIDTH-1:0] diff,
    output logic             carry_out,
    output logic             carry_msb
);
    always_comb begin
        logic c;
        c = carry_in;
        diff = '0;
        carry_out = 1'b0;
        carry_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ ~b[i] ^ c;
            if (real_mask[i]) begin
                carry_msb = c;
                carry_out = (a[i] & ~b[i]) | (c & (a[i] ^ ~b[i]));
            end
            c = (a[i] & ~b[i]) | (c & (a[i] ^ ~b[i]));
        end
    end
endmodule

// File: rtl/arithmetic_predicates_serial.sv
// arithmetic_predicates_serial: multi-cycle signed/unsigned compare of A and B, one slice per cycle.
// Define ARITH_PRED_MINMAX_EN to add registered min/max outputs.
module arithmetic_predicates_serial
    import arith_pred_pkg::*;
#(
    parameter int WORD_WIDTH      = 64,
    parameter int STEP_WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  clock_enable,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] B,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic                  A_eq_B,
    output logic                  A_lt_B_unsigned,
    output logic                  A_lte_B_unsigned,
    output logic                  A_gt_B_unsigned,
    output logic                  A_gte_B_unsigned,
    output logic                  A_lt_B_signed,
    output logic                  A_lte_B_signed,
    output logic                  A_gt_B_signed,
    output logic                  A_gte_B_signed
`ifdef ARITH_PRED_MINMAX_EN
    ,
    output logic [WORD_WIDTH-1:0] min_unsigned,
    output logic [WORD_WIDTH-1:0] max_unsigned,
    output logic [WORD_WIDTH-1:0] min_signed,
    output logic [WORD_WIDTH-1:0] max_signed
`endif
);
    localparam int SC   = step_count(WORD_WIDTH, STEP_WORD_WIDTH);
    localparam int PW   = SC * STEP_WORD_WIDTH;
    localparam int CW   = $clog2(SC) + 1;
    localparam int LAST = (WORD_WIDTH - 1) % STEP_WORD_WIDTH;
    localparam logic [STEP_WORD_WIDTH-1:0] LAST_MASK = {STEP_WORD_WIDTH{1'b1}} >> (STEP_WORD_WIDTH - 1 - LAST);
    localparam logic [CW-1:0] CNT_LAST = CW'(SC - 1);

    state_t                     state;
    logic [PW-1:0]              a_sh, b_sh;
    logic [CW-1:0]              cnt;
    logic                       carry, zero;
    logic [STEP_WORD_WIDTH-1:0] diff, real_mask;
    logic                       c_out, c_msb, last, accept, eq_n, lt_u, lt_s;

    assign input_ready  = state == IDLE || (state == DONE && output_ready);
    assign output_valid = state == DONE;
    assign accept       = clock_enable && input_valid && input_ready;
    assign last         = cnt == CNT_LAST;
    // Only the final slice carries padding; its carries and zero test stop at bit WORD_WIDTH-1.
    assign real_mask    = last ? LAST_MASK : '1;

    arith_pred_step #(.WIDTH(STEP_WORD_WIDTH)) u_step (
        .a        (a_sh[STEP_WORD_WIDTH-1:0]),
        .b        (b_sh[STEP_WORD_WIDTH-1:0]),
        .carry_in (carry),
        .real_mask(real_mask),
        .diff     (diff),
        .carry_out(c_out),
        .carry_msb(c_msb)
    );

    always_comb begin
        eq_n = zero && ((diff & real_mask) == '0);
        lt_u = !c_out;
        lt_s = diff[LAST] ^ c_msb ^ c_out;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state            <= IDLE;
            a_sh             <= '0;
            b_sh             <= '0;
            cnt              <= '0;
            carry            <= 1'b0;
            zero             <= 1'b0;
            A_eq_B           <= 1'b0;
            A_lt_B_unsigned  <= 1'b0;
            A_lte_B_unsigned <= 1'b0;
            A_gt_B_unsigned  <= 1'b0;
            A_gte_B_unsigned <= 1'b0;
            A_lt_B_signed    <= 1'b0;
            A_lte_B_signed   <= 1'b0;
            A_gt_B_signed    <= 1'b0;
            A_gte_B_signed   <= 1'b0;
        end else if (clock_enable) begin
            if (accept) begin
                state <= RUN;
                a_sh  <= PW'(A);
                b_sh  <= PW'(B);
                cnt   <= '0;
                carry <= 1'b1;
                zero  <= 1'b1;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> STEP_WORD_WIDTH;
                b_sh  <= b_sh >> STEP_WORD_WIDTH;
                cnt   <= cnt + 1'b1;
                carry <= c_out;
                zero  <= eq_n;
                if (last) begin
                    state            <= DONE;
                    A_eq_B           <= eq_n;
                    A_lt_B_unsigned  <= lt_u;
                    A_lte_B_unsigned <= lt_u || eq_n;
                    A_gt_B_unsigned  <= !lt_u && !eq_n;
                    A_gte_B_unsigned <= !lt_u;
                    A_lt_B_signed    <= lt_s;
                    A_lte_B_signed   <= lt_s || eq_n;
                    A_gt_B_signed    <= !lt_s && !eq_n;
                    A_gte_B_signed   <= !lt_s;
                end
            end else if (state == DONE && output_ready) begin
                state <= IDLE;
            end
        end
    end

`ifdef ARITH_PRED_MINMAX_EN
    logic [WORD_WIDTH-1:0] a_keep, b_keep;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            a_keep       <= '0;
            b_keep       <= '0;
            min_unsigned <= '0;
            max_unsigned <= '0;
            min_signed   <= '0;
            max_signed   <= '0;
        end else if (clock_enable) begin
            if (accept) begin
                a_keep <= A;
                b_keep <= B;
            end else if (state == RUN && last) begin
                min_unsigned <= (lt_u || eq_n) ? a_keep : b_keep;
                max_unsigned <= !lt_u ? a_keep : b_keep;
                min_signed   <= (lt_s || eq_n) ? a_keep : b_keep;
                max_signed   <= !lt_s ? a_keep : b_keep;
            end
        end
    end
`endif
endmodule

// File: tb/tb_arithmetic_predicates_serial.sv
// tb_arithmetic_predicates_serial: scoreboard bench for the serial comparator at 8-bit words, 3-bit steps.
module tb_arithmetic_predicates_serial;
    localparam int W  = 8;
    localparam int S  = 3;
    localparam int SC = 3;

    typedef struct packed {
        logic [8:0]  p;
        logic [31:0] mm;
    } res_t;

    logic         clock = 1'b0, clear_n = 1'b0, clock_enable = 1'b1;
    logic         input_valid = 1'b0, output_ready = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         input_ready, output_valid;
    logic         A_eq_B, A_lt_B_unsigned, A_lte_B_unsigned, A_gt_B_unsigned, A_gte_B_unsigned;
    logic         A_lt_B_signed, A_lte_B_signed, A_gt_B_signed, A_gte_B_signed;
`ifdef ARITH_PRED_MINMAX_EN
    logic [W-1:0] min_unsigned, max_unsigned, min_signed, max_signed;
`endif

    res_t sb[$];
    int   errors = 0, checks = 0;

    always #5 clock = ~clock;

    arithmetic_predicates_serial #(.WORD_WIDTH(W), .STEP_WORD_WIDTH(S)) dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .clock_enable    (clock_enable),
        .input_valid     (input_valid),
        .input_ready     (input_ready),
        .A               (A),
        .B               (B),
        .output_valid    (output_valid),
        .output_ready    (output_ready),
        .A_eq_B          (A_eq_B),
        .A_lt_B_unsigned (A_lt_B_unsigned),
        .A_lte_B_unsigned(A_lte_B_unsigned),
        .A_gt_B_unsigned (A_gt_B_unsigned),
        .A_gte_B_unsigned(A_gte_B_unsigned),
        .A_lt_B_signed   (A_lt_B_signed),
        .A_lte_B_signed  (A_lte_B_signed),
        .A_gt_B_signed   (A_gt_B_signed),
        .A_gte_B_signed  (A_gte_B_signed)
`ifdef ARITH_PRED_MINMAX_EN
        ,
        .min_unsigned    (min_unsigned),
        .max_unsigned    (max_unsigned),
        .min_signed      (min_signed),
        .max_signed      (max_signed)
`endif
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic eq, ltu, lts;
        eq  = a == b;
        ltu = a < b;
        lts = $signed(a) < $signed(b);
        r.p = {eq, ltu, ltu | eq, !ltu & !eq, !ltu, lts, lts | eq, !lts & !eq, !lts};
`ifdef ARITH_PRED_MINMAX_EN
        r.mm = {(ltu | eq) ? a : b, !ltu ? a : b, (lts | eq) ? a : b, !lts ? a : b};
`else
        r.mm = '0;
`endif
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.p = {A_eq_B, A_lt_B_unsigned, A_lte_B_unsigned, A_gt_B_unsigned, A_gte_B_unsigned,
               A_lt_B_signed, A_lte_B_signed, A_gt_B_signed, A_gte_B_signed};
`ifdef ARITH_PRED_MINMAX_EN
        r.mm = {min_unsigned, max_unsigned, min_signed, max_signed};
`else
        r.mm = '0;
`endif
        return r;
    endfunction

    // Presents one operand pair from IDLE; returns 1ns after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clock); #1;
        A = a;
        B = b;
        input_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clock); #1;
        input_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!output_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        #12;
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1)
            $display("FAIL reset_handshake: valid=%b ready=%b want valid=0 ready=1", output_valid, input_ready);
        if (output_valid !== 1'b0 || input_ready !== 1'b1) errors++;
        checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_preds: got %h want 0", observed());
        end
        @(posedge clock); #1;
        clear_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] pa[12] = '{8'h5A, 8'h80, 8'h00, 8'h01, 8'hFF, 8'h7F, 8'hFF, 8'h00, 8'h40, 8'hC0, 8'h12, 8'hFE};
        logic [W-1:0] pb[12] = '{8'h5A, 8'h7F, 8'hFF, 8'h02, 8'h00, 8'h80, 8'hFF, 8'h00, 8'hC0, 8'h40, 8'h13, 8'hFF};
        res_t exp;
        int   n;
        for (int i = 0; i < 16; i++) begin
            if (i < 12) launch(pa[i], pb[i]);
            else launch(W'($urandom), W'($urandom));
            wait_valid(n);
            checks++;
            if (n !== SC) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, n, SC);
            end
            exp = sb.pop_front();
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL basic_result[%0d] A=%h B=%h: got %h want %h", i, A, B, observed(), exp);
            end
            output_ready = 1'b1;
            @(posedge clock); #1;
            output_ready = 1'b0;
            checks++;
            if (output_valid !== 1'b0 || input_ready !== 1'b1 || observed() !== exp) begin
                errors++;
                $display("FAIL basic_idle_retain[%0d]: valid=%b ready=%b preds=%h want 0/1/%h",
                         i, output_valid, input_ready, observed(), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   idx = 0, pulses = 0, first = -1, second = -1;
        res_t exp;
        output_ready = 1'b1;
        @(posedge clock); #1;
        A = 8'h11;
        B = 8'h22;
        input_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clock);
            if (output_valid) begin
                pulses++;
                if (first < 0) first = cyc;
                else second = cyc;
                exp = sb.pop_front();
                checks++;
                if (observed() !== exp) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %h want %h", pulses, observed(), exp);
                end
            end
            if (input_valid && input_ready) begin
                if (idx == 1) begin
                    checks++;
                    if (output_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_accept_in_done: output_valid=%b want 1", output_valid);
                    end
                end
                sb.push_back(model(A, B));
                idx++;
                @(posedge clock); #1;
                if (idx == 1) begin
                    A = 8'h90;
                    B = 8'h05;
                end else input_valid = 1'b0;
            end else begin
                @(posedge clock); #1;
            end
        end
        output_ready = 1'b0;
        checks++;
        if (pulses !== 2 || second - first - 1 !== SC) begin
            errors++;
            $display("FAIL b2b_gap: pulses=%0d gap=%0d want pulses=2 gap=%0d", pulses, second - first - 1, SC);
        end
    endtask

    task automatic test_hold();
        res_t exp;
        int   n;
        launch(8'h33, 8'h44);
        wait_valid(n);
        exp = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (output_valid !== 1'b1 || input_ready !== 1'b0 || observed() !== exp) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b ready=%b preds=%h want 1/0/%h",
                         i, output_valid, input_ready, observed(), exp);
            end
            @(posedge clock); #1;
        end
        output_ready = 1'b1;
        @(posedge clock); #1;
        output_ready = 1'b0;
        checks++;
        if (output_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: output_valid=%b want 0", output_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        res_t exp;
        int   n;
        logic seen = 1'b0;
        launch(8'h99, 8'h10);
        @(posedge clock); #1;
        clear_n = 1'b0;
        #1;
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1 || observed() !== '0) begin
            errors++;
            $display("FAIL midrun_reset: valid=%b ready=%b preds=%h want 0/1/0", output_valid, input_ready, observed());
        end
        sb.delete();
        @(posedge clock); #1;
        clear_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (output_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_valid: saw valid=%b want 0", seen);
        end
        launch(8'h01, 8'h02);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (observed() !== exp || A_lt_B_unsigned !== 1'b1 || A_lt_B_signed !== 1'b1) begin
            errors++;
            $display("FAIL midrun_next_op: got %h want %h", observed(), exp);
        end
        output_ready = 1'b1;
        @(posedge clock); #1;
        output_ready = 1'b0;
    endtask

    task automatic test_enable();
        res_t exp;
        int   n;
        logic seen = 1'b0;
        launch(8'hC3, 8'h3C);
        @(posedge clock); #1;
        clock_enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clock_enable = 1'b1;
        wait_valid(n);
        checks++;
        if (n + 3 !== SC + 2) begin
            errors++;
            $display("FAIL enable_latency: got %0d want %0d", n + 3, SC + 2);
        end
        exp = sb.pop_front();
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL enable_result: got %h want %h", observed(), exp);
        end
        output_ready = 1'b1;
        @(posedge clock); #1;
        output_ready = 1'b0;
        clock_enable = 1'b0;
        A = 8'h07;
        B = 8'h07;
        input_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        input_valid = 1'b0;
        clock_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (output_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL enable_blocks_handshake: saw valid=%b want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arithmetic_predicates_serial.md
ARITHMETIC_PREDICATES_SERIAL -- requirements
Module: arithmetic_predicates_serial

Interface
REQ-001 Parameter WORD_WIDTH, default 64: operand width in bits, minimum 2.
REQ-002 Parameter STEP_WORD_WIDTH, default 16: bits processed per step, 1 to WORD_WIDTH.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port clear_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port clock_enable, input, 1: when low, all state and outputs are held.
REQ-006 Ports input_valid (in, 1), input_ready (out, 1): operand handshake.
REQ-007 Ports A, B, input, WORD_WIDTH each: operands, sampled only on input handshake.
REQ-008 Ports output_valid (out, 1), output_ready (in, 1): result handshake.
REQ-009 Ports A_eq_B, A_lt/lte/gt/gte_B_unsigned, A_lt/lte/gt/gte_B_signed, output, 1 each: registered predicates.

Function
REQ-010 STEP_COUNT SHALL equal ceil(WORD_WIDTH/STEP_WORD_WIDTH); operands SHALL be zero-padded to STEP_COUNT*STEP_WORD_WIDTH, and padding bits SHALL NOT affect any result.
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 input_ready SHALL be high in IDLE, and in DONE when output_ready is high; it SHALL be low otherwise.
REQ-013 On an input handshake, the block SHALL latch A and B, set carry=1 and zero=1, clear the step counter, and enter RUN.
REQ-014 Each RUN cycle SHALL compute one LSB-first slice of A+~B+carry, update carry, AND zero with (slice==0) over real bits only, and shift the operands by STEP_WORD_WIDTH.
REQ-015 Unsigned carry_out SHALL be the carry out of bit WORD_WIDTH-1.
REQ-016 Signed overflow SHALL be the carry into bit WORD_WIDTH-1 XOR the carry out of bit WORD_WIDTH-1.
REQ-017 negative SHALL be difference bit WORD_WIDTH-1.
REQ-018 After the STEP_COUNT-th RUN cycle, the FSM SHALL enter DONE with output_valid=1 and registered predicates; acceptance at edge k SHALL give output_valid high after edge k+STEP_COUNT.
REQ-019 The predicates SHALL be:
  - eq = zero;
  - lt_u = !carry_out; gte_u = carry_out;
  - lte_u = lt_u|eq; gt_u = gte_u&!eq;
  - lt_s = negative^overflow; gte_s = !lt_s;
  - lte_s = lt_s|eq; gt_s = gte_s&!eq.
REQ-020 In DONE with output_ready low, all outputs SHALL hold stable.
REQ-021 DONE with output_ready high and input_valid high SHALL accept the new operands into RUN in the same cycle (back-to-back).
REQ-022 DONE with output_ready high and input_valid low SHALL go to IDLE with output_valid=0; predicates SHALL retain their last values.
REQ-023 In IDLE and RUN, output_valid SHALL be 0.
REQ-024 When clock_enable is low, no handshake SHALL complete and no state SHALL change.

Reset
REQ-025 On clear_n low, the FSM SHALL go to IDLE immediately.
REQ-026 Reset values SHALL be: output_valid=0, input_ready=1, all predicates 0, counter/carry/zero 0.
REQ-027 Reset mid-RUN SHALL discard the operation; no result SHALL appear after reset release.

Configuration
REQ-028 With macro ARITH_PRED_MINMAX_EN defined, the block SHALL keep unshifted copies of A and B and add output ports min_unsigned, max_unsigned, min_signed, max_signed (WORD_WIDTH each), registered on DONE entry, with the lesser/greater operand per the predicates and A on equality.
REQ-029 Without ARITH_PRED_MINMAX_EN, those ports and the operand copies SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package arith_pred_pkg SHALL hold the FSM state enum and a step_count(WORD_WIDTH, STEP_WORD_WIDTH) constant function.
REQ-031 One sub-module, arith_pred_step, SHALL implement the STEP_WORD_WIDTH-bit slice subtract with carry_in, carry_out, and a carry-into-MSB output.

Verification (WORD_WIDTH=8, STEP_WORD_WIDTH=3, STEP_COUNT=3, one padding bit)
REQ-032 A=0x5A, B=0x5A -> output_valid 3 cycles after accept; eq, lte_u, gte_u, lte_s, gte_s =1; all others 0.
REQ-033 A=0x80, B=0x7F -> gt_u=gte_u=1; lt_s=lte_s=1 (overflow path); eq=0.
REQ-034 A=0x00, B=0xFF -> lt_u=1, gt_s=1; with ARITH_PRED_MINMAX_EN: min_unsigned=0x00, max_signed=0x00.
REQ-035 Two back-to-back ops with output_ready held high -> second accepted in DONE cycle; valid pulses separated by 3 cycles.
REQ-036 output_ready low 5 cycles in DONE -> outputs stable, input_ready=0.
REQ-037 clear_n low during RUN -> valid never rises; next op A=0x01, B=0x02 -> lt_u=lt_s=1.
REQ-038 clock_enable low for 2 RUN cycles -> latency extended by exactly 2 cycles.
